// File: rtl/note_tone_player.sv
// Plays a latched 3-bit note code as a square wave on the buzzer for a fixed duration.
// A one-cycle completion pulse follows each note, then the block waits for note_valid to be released.
module note_tone_player #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DUR_CYCLES = 12_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [2:0] note_code,
    input  logic       mute,
    output logic       buzzer,
    output logic       playing,
    output logic       note_done,
    output logic [1:0] db_state,
    output logic [2:0] db_note
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        DONE     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam int DW = $clog2(DUR_CYCLES + 1);
    localparam logic [DW-1:0] DUR_LAST = DW'(DUR_CYCLES - 1);
    localparam logic [DW-1:0] DUR_MAX  = DW'(DUR_CYCLES);
    localparam logic [2:0]    REST     = 3'd7;

    function automatic logic [16:0] half_of(input logic [2:0] code);
        case (code)
            3'd0:    half_of = 17'(CLK_HZ / (2 * 262));
            3'd1:    half_of = 17'(CLK_HZ / (2 * 294));
            3'd2:    half_of = 17'(CLK_HZ / (2 * 330));
            3'd3:    half_of = 17'(CLK_HZ / (2 * 349));
            3'd4:    half_of = 17'(CLK_HZ / (2 * 392));
            3'd5:    half_of = 17'(CLK_HZ / (2 * 440));
            3'd6:    half_of = 17'(CLK_HZ / (2 * 494));
            default: half_of = 17'd0;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic            tone_q, tone_d;
    logic            playing_q, playing_d;
    logic            note_done_q, note_done_d;
    logic [2:0]      note_q, note_d;
    logic [16:0]     half_q, half_d;
    logic [DW-1:0]   dur_q, dur_d;
    logic [16:0]     half_len;

    always_comb begin
        state_d     = state_q;
        tone_d      = tone_q;
        playing_d   = playing_q;
        note_done_d = 1'b0;
        note_d      = note_q;
        half_d      = half_q;
        dur_d       = dur_q;
        half_len    = half_of(note_q);

        case (state_q)
            IDLE: begin
                tone_d    = 1'b0;
                playing_d = 1'b0;
                if (note_valid) begin
                    state_d   = PLAY;
                    playing_d = 1'b1;
                    tone_d    = (note_code != REST);
                    note_d    = note_code;
                    half_d    = 17'd0;
                    dur_d     = '0;
                end
            end
            PLAY: begin
                dur_d = (dur_q == DUR_MAX) ? dur_q : dur_q + 1'b1;
                if (note_q != REST) begin
                    if (half_q == half_len - 17'd1) begin
                        half_d = 17'd0;
                        tone_d = ~tone_q;
                    end else begin
                        half_d = half_q + 17'd1;
                    end
                end
                // Release beats completion when both land on the same cycle.
                if (!note_valid) begin
                    state_d   = IDLE;
                    tone_d    = 1'b0;
                    playing_d = 1'b0;
                end else if (dur_q == DUR_LAST) begin
                    state_d     = DONE;
                    tone_d      = 1'b0;
                    playing_d   = 1'b0;
                    note_done_d = 1'b1;
                end
            end
            DONE: begin
                tone_d    = 1'b0;
                playing_d = 1'b0;
                state_d   = note_valid ? WAIT_REL : IDLE;
            end
            default: begin
                tone_d    = 1'b0;
                playing_d = 1'b0;
                if (!note_valid) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            tone_q      <= 1'b0;
            playing_q   <= 1'b0;
            note_done_q <= 1'b0;
            note_q      <= 3'd0;
            half_q      <= 17'd0;
            dur_q       <= '0;
        end else begin
            state_q     <= state_d;
            tone_q      <= tone_d;
            playing_q   <= playing_d;
            note_done_q <= note_done_d;
            note_q      <= note_d;
            half_q      <= half_d;
            dur_q       <= dur_d;
        end
    end

    assign buzzer    = tone_q & ~mute;
    assign playing   = playing_q;
    assign note_done = note_done_q;
    assign db_state  = state_q;
    assign db_note   = note_q;
endmodule

// File: tb/tb_note_tone_player.sv
// Randomized and directed bench for note_tone_player against an elapsed-time model of each note.
module tb_note_tone_player;
    localparam int CLK_HZ = 52400;
    localparam int DUR    = 1000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       note_valid = 1'b0;
    logic [2:0] note_code = 3'd0;
    logic       mute = 1'b0;
    logic       buzzer, playing, note_done;
    logic [1:0] db_state;
    logic [2:0] db_note;

    note_tone_player #(.CLK_HZ(CLK_HZ), .DUR_CYCLES(DUR)) dut (
        .clock(clock), .reset(reset), .note_valid(note_valid), .note_code(note_code),
        .mute(mute), .buzzer(buzzer), .playing(playing), .note_done(note_done),
        .db_state(db_state), .db_note(db_note)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int half_of(input int n);
        int f;
        case (n)
            0: f = 262;
            1: f = 294;
            2: f = 330;
            3: f = 349;
            4: f = 392;
            5: f = 440;
            default: f = 494;
        endcase
        return CLK_HZ / (2 * f);
    endfunction

    // Model: mode 0 idle, 1 playing, 2 done, 3 waiting for release; m_el counts cycles into the note.
    int m_mode = 0;
    int m_el   = 0;
    int m_note = 0;
    bit m_done = 0;

    always @(posedge clock) begin
        m_done = 0;
        if (reset) begin
            m_mode = 0;
            m_el   = 0;
            m_note = 0;
        end else begin
            case (m_mode)
                0: if (note_valid) begin m_mode = 1; m_note = note_code; m_el = 0; end
                1: begin
                    if (!note_valid) m_mode = 0;
                    else if (m_el == DUR - 1) begin m_mode = 2; m_done = 1; end
                    else m_el++;
                end
                2: m_mode = note_valid ? 3 : 0;
                default: if (!note_valid) m_mode = 0;
            endcase
        end
    end

    always @(posedge clock) begin
        bit exp_bz;
        #1;
        exp_bz = (m_mode == 1) && (m_note != 7) && !mute && (((m_el / half_of(m_note)) % 2) == 0);
        check("buzzer", {31'd0, buzzer}, {31'd0, exp_bz});
        check("playing", {31'd0, playing}, {31'd0, (m_mode == 1)});
        check("note_done", {31'd0, note_done}, {31'd0, m_done});
        check("db_state", {30'd0, db_state}, 32'(m_mode));
        check("db_note", {29'd0, db_note}, 32'(m_note));
    end

    int play_n, done_n, rise_n, max_hi, run_hi, mute_bz;
    logic prev_bz;

    task automatic clear_counts();
        play_n = 0; done_n = 0; rise_n = 0; max_hi = 0; run_hi = 0; mute_bz = 0;
        prev_bz = buzzer;
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (playing) play_n++;
            if (note_done) done_n++;
            if (buzzer && !prev_bz) rise_n++;
            run_hi = buzzer ? run_hi + 1 : 0;
            if (run_hi > max_hi) max_hi = run_hi;
            if (mute && buzzer) mute_bz++;
            prev_bz = buzzer;
        end
    endtask

    task automatic release_valid();
        note_valid = 1'b0;
        run_count(3);
    endtask

    initial begin
        int len, rst_at;
        check("half_c4", 32'(half_of(0)), 32'd100);
        check("half_a4", 32'(half_of(5)), 32'd59);

        repeat (2) @(negedge clock);
        check("rst_playing", {31'd0, playing}, 32'd0);
        check("rst_state", {30'd0, db_state}, 32'd0);

        // Test 1: C4 held high through completion.
        reset = 1'b0; note_valid = 1'b1; note_code = 3'd0;
        clear_counts();
        run_count(1010);
        check("t1_play_len", 32'(play_n), 32'd1000);
        check("t1_rises", 32'(rise_n), 32'd5);
        check("t1_max_hi", 32'(max_hi), 32'd100);
        check("t1_done", 32'(done_n), 32'd1);
        check("t1_wait_rel", {30'd0, db_state}, 32'd3);
        release_valid();

        // Test 2: A4.
        note_code = 3'd5; note_valid = 1'b1;
        clear_counts();
        run_count(1010);
        check("t2_play_len", 32'(play_n), 32'd1000);
        check("t2_rises", 32'(rise_n), 32'd9);
        check("t2_max_hi", 32'(max_hi), 32'd59);
        release_valid();

        // Test 3: rest.
        note_code = 3'd7; note_valid = 1'b1;
        clear_counts();
        run_count(1010);
        check("t3_play_len", 32'(play_n), 32'd1000);
        check("t3_rises", 32'(rise_n), 32'd0);
        check("t3_done", 32'(done_n), 32'd1);
        release_valid();

        // Test 4: abort at cycle 400, then a fresh note.
        note_code = 3'd0; note_valid = 1'b1;
        clear_counts();
        run_count(400);
        note_valid = 1'b0;
        run_count(20);
        check("t4_abort_len", 32'(play_n), 32'd400);
        check("t4_no_done", 32'(done_n), 32'd0);
        check("t4_idle", {30'd0, db_state}, 32'd0);
        note_valid = 1'b1;
        clear_counts();
        run_count(1010);
        check("t4_fresh_len", 32'(play_n), 32'd1000);
        check("t4_fresh_done", 32'(done_n), 32'd1);
        release_valid();

        // Test 5: reset mid-note with valid held.
        note_code = 3'd2; note_valid = 1'b1;
        clear_counts();
        run_count(300);
        reset = 1'b1;
        run_count(1);
        check("t5_rst_playing", {31'd0, playing}, 32'd0);
        check("t5_rst_buzzer", {31'd0, buzzer}, 32'd0);
        check("t5_rst_done", {31'd0, note_done}, 32'd0);
        check("t5_rst_state", {30'd0, db_state}, 32'd0);
        check("t5_rst_note", {29'd0, db_note}, 32'd0);
        reset = 1'b0;
        run_count(1);
        check("t5_restart", {31'd0, playing}, 32'd1);
        release_valid();

        // Test 6: mute toggles and a code change mid-note.
        note_code = 3'd4; note_valid = 1'b1;
        clear_counts();
        for (int i = 0; i < 1010; i++) begin
            mute = ((i % 150) >= 100);
            if (i == 500) note_code = 3'd1;
            run_count(1);
        end
        mute = 1'b0;
        check("t6_play_len", 32'(play_n), 32'd1000);
        check("t6_mute_bz", 32'(mute_bz), 32'd0);
        check("t6_db_note", {29'd0, db_note}, 32'd4);
        release_valid();

        // Randomized notes, aborts, mute and occasional reset.
        for (int it = 0; it < 25; it++) begin
            note_code = 3'($urandom_range(0, 7));
            note_valid = 1'b1;
            len = $urandom_range(1, 1100);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len) : -1;
            for (int i = 0; i < len; i++) begin
                @(negedge clock);
                reset = (i == rst_at);
                if ($urandom_range(0, 49) == 0) mute = ~mute;
                if ($urandom_range(0, 99) == 0) note_code = 3'($urandom_range(0, 7));
            end
            @(negedge clock);
            reset = 1'b0;
            note_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clock);
        end

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
